regfile_seq: RTL and testbench
==============================

# regfile_seq

Micro-sequencer that drives the 7-entry register file (select lines `ASEL`/`BSEL`/`DSEL`) and an external ALU. It accepts one 16-bit instruction at a time over a valid/ready handshake and runs read → execute → write-back on the register file. It waits on a variable-latency ALU with a cycle-count timeout, and counts retired instructions. It sits between the instruction source and the register-file/ALU datapath, and is the only driver of the register-file select lines.

## Interface
- `TIMEOUT_CYC`, default 15: maximum EXEC cycles allowed before abort; legal range 1..255.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports (all outputs registered except `IREADY`):
- `CLK`  in  1  clock; all state updates on posedge.
- `RST`  in  1  reset, asynchronous, active-low.
- `INSTR`  in  16  instruction: [15:12] opcode, [11:9] dst, [8:6] srcA, [5:3] srcB, [2:0] ignored.
- `IVALID`  in  1  instruction valid.
- `IREADY`  out  1  sequencer can accept; equals (state == IDLE).
- `ASEL`  out  3  A-bus select to register file (0 selects the `DIN` bypass).
- `BSEL`  out  3  B-bus select to register file.
- `DSEL`  out  3  write select to register file; non-zero only in WRITE.
- `ALUOP`  out  4  operation code to ALU; equals the latched opcode.
- `ALU_GO`  out  1  one-cycle start pulse to ALU.
- `ALU_DONE`  in  1  ALU result valid on `RIN` this cycle.
- `HALTED`  out  1  sticky; set by HALT opcode.
- `TIMEOUT`  out  1  sticky; set by ALU timeout.
- `RETIRED`  out  `CNT_W`  count of completed instructions (NOP, ALU ops, HALT).

## Operation
- Opcodes: 0 = NOP, 1..14 = ALU op (passed on `ALUOP`), 15 = HALT.
- States: IDLE, DECODE, EXEC, WRITE, HALT.
- IDLE
  - `IREADY`=1.
  - When `IVALID && IREADY`, latch `INSTR` and go to DECODE.
- DECODE
  - NOP: increment `RETIRED`, go to IDLE.
  - HALT: increment `RETIRED`, set `HALTED`, go to HALT.
  - ALU op: drive `ASEL`=srcA, `BSEL`=srcB, `ALUOP`; go to EXEC with `ALU_GO`=1.
- EXEC
  - `ALU_GO` is high for the first EXEC cycle only; `ASEL`/`BSEL`/`ALUOP` are held stable.
  - `ALU_DONE` is sampled every EXEC cycle, including the first.
  - `ALU_DONE`=1: go to WRITE.
  - Otherwise the timer increments. When the timer reaches `TIMEOUT_CYC`, set `TIMEOUT`, go to IDLE; no write, `RETIRED` unchanged.
- WRITE
  - Exactly one cycle with `DSEL`=dst; `ASEL`/`BSEL` held. The register file captures `RIN` at the closing edge.
  - dst=0 gives `DSEL`=0, so the result is discarded; this still counts as retired.
  - Increment `RETIRED`, go to IDLE.
- HALT
  - Terminal until reset: `IREADY`=0, all selects 0, `ALU_GO`=0.
- `DSEL` is 0 in every state except WRITE; a spurious non-zero `DSEL` corrupts the register file.
- `ALU_DONE` outside EXEC is ignored.
- `RETIRED` wraps modulo 2^`CNT_W`.
- `TIMEOUT` does not block further instructions.

## Timing
- Reset values:
  - state = IDLE.
  - `ASEL`, `BSEL`, `DSEL`, `ALUOP`, `ALU_GO`, `HALTED`, `TIMEOUT`, `RETIRED` = 0.
  - `IREADY` = 1 once reset is released.
- Reset mid-operation: state returns to IDLE and `DSEL` goes to 0 asynchronously; the in-flight instruction is dropped and nothing is written.
- Minimum ALU instruction: accept at edge 0; DECODE in cycle 1; EXEC with `ALU_GO` in cycle 2 (`ALU_DONE` in cycle 2); WRITE in cycle 3; `IREADY`=1 again in cycle 4. Throughput is one ALU instruction per 4 cycles.
- NOP throughput: one per 2 cycles.
- An ALU reply arriving N cycles after the `ALU_GO` cycle (N < `TIMEOUT_CYC`) puts WRITE N+1 cycles after the `ALU_GO` cycle.
- Timeout: `TIMEOUT` is set and the state returns to IDLE at the edge ending EXEC cycle `TIMEOUT_CYC` (counting the `ALU_GO` cycle as 1).
- `ALU_DONE` arriving in the same cycle the timer reaches its limit counts as done: WRITE, no timeout.

## Structure
- Shared header `regfile_seq_defs.vh` holds:
  - opcode constants `OP_NOP`=0 and `OP_HALT`=15;
  - state encodings;
  - instruction field bit positions.
- One sub-module: `seq_timer` — an 8-bit up-counter with clear, enable, and a terminal flag `count == TIMEOUT_CYC`, parameterised by `TIMEOUT_CYC`.

## Test plan
- Reset, then INSTR=0x1450 (op1, dst2, srcA1, srcB2), `ALU_DONE` in the first EXEC cycle:
  - `ASEL`=1, `BSEL`=2, `ALU_GO` pulse in cycle 2;
  - `DSEL`=2 for exactly cycle 3, then 0;
  - `RETIRED`=1, `IREADY`=1 in cycle 4.
- `ALU_DONE` 5 cycles after `ALU_GO`: `ALU_GO` is a single pulse; WRITE comes 6 cycles after `ALU_GO`; `DSEL` is 0 in all other cycles.
- `ALU_DONE` never asserted with `TIMEOUT_CYC`=15: `TIMEOUT`=1 after 15 EXEC cycles, no non-zero `DSEL`, `RETIRED` unchanged. The next NOP is still accepted and raises `RETIRED` by 1.
- Back-to-back NOPs, then HALT (0xF000), then further `IVALID`:
  - `RETIRED` increments on every instruction;
  - `HALTED`=1 and `IREADY` stays 0;
  - later instructions are ignored until `RST` pulses low.
- `RST` driven low during WRITE with dst=5: `DSEL` drops to 0 immediately, all outputs return to reset values, and `IREADY`=1 after release.
- ALU op with dst=0 and `ALU_DONE` pulsed while in IDLE: the IDLE pulse is ignored; the instruction completes with `DSEL`=0 throughout and `RETIRED` increments.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file micro-sequencer: opcodes,
// FSM state encoding and instruction field positions.
package regfile_seq_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam int unsigned OP_HI   = 15;
   localparam int unsigned OP_LO   = 12;
   localparam int unsigned DST_HI  = 11;
   localparam int unsigned DST_LO  = 9;
   localparam int unsigned SRCA_HI = 8;
   localparam int unsigned SRCA_LO = 6;
   localparam int unsigned SRCB_HI = 5;
   localparam int unsigned SRCB_LO = 3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WRITE  = 3'd3,
      S_HALT   = 3'd4
   } state_t;

endpackage

// File: rtl/seq_timer.sv
// EXEC-phase cycle counter: 8-bit up-counter with synchronous clear,
// count enable and a terminal flag at TIMEOUT_CYC.
module seq_timer #(
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic CLK,
   input  logic RST,
   input  logic CLR,
   input  logic EN,
   output logic TERM
);

   logic [7:0] count;

   // Count enabled cycles; clear has priority over enable.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         count <= '0;
      end else if (CLR) begin
         count <= '0;
      end else if (EN) begin
         count <= count + 8'd1;
      end
   end

   assign TERM = (count == 8'(TIMEOUT_CYC));

endmodule

// File: rtl/regfile_seq.sv
// Register-file micro-sequencer: accepts one instruction over valid/ready,
// drives register-file selects and the ALU through read/exec/write-back,
// with an EXEC timeout and a retired-instruction counter.
module regfile_seq
   import regfile_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [15:0]      INSTR,
   input  logic             IVALID,
   output logic             IREADY,
   output logic [2:0]       ASEL,
   output logic [2:0]       BSEL,
   output logic [2:0]       DSEL,
   output logic [3:0]       ALUOP,
   output logic             ALU_GO,
   input  logic             ALU_DONE,
   output logic             HALTED,
   output logic             TIMEOUT,
   output logic [CNT_W-1:0] RETIRED
);

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [2:0]       dst_q, dst_d;
   logic [2:0]       srca_q, srca_d;
   logic [2:0]       srcb_q, srcb_d;
   logic [2:0]       asel_q, asel_d;
   logic [2:0]       bsel_q, bsel_d;
   logic [2:0]       dsel_q, dsel_d;
   logic             go_q, go_d;
   logic             halted_q, halted_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             tmr_clr, tmr_en, tmr_term;
   logic             unused_instr_bits;

   assign unused_instr_bits = ^INSTR[2:0];

   // Timer runs through DECODE and EXEC so its value equals the EXEC cycle
   // number (GO cycle = 1) while in EXEC.
   seq_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .CLK  (CLK),
      .RST  (RST),
      .CLR  (tmr_clr),
      .EN   (tmr_en),
      .TERM (tmr_term)
   );

   // Next-state and next-output logic for the sequencer FSM.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      dst_d     = dst_q;
      srca_d    = srca_q;
      srcb_d    = srcb_q;
      asel_d    = asel_q;
      bsel_d    = bsel_q;
      dsel_d    = '0;
      go_d      = 1'b0;
      halted_d  = halted_q;
      timeout_d = timeout_q;
      retired_d = retired_q;
      tmr_clr   = 1'b1;
      tmr_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (IVALID) begin
               op_d    = INSTR[OP_HI:OP_LO];
               dst_d   = INSTR[DST_HI:DST_LO];
               srca_d  = INSTR[SRCA_HI:SRCA_LO];
               srcb_d  = INSTR[SRCB_HI:SRCB_LO];
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            tmr_clr = 1'b0;
            tmr_en  = 1'b1;
            if (op_q == OP_NOP) begin
               retired_d = retired_q + CNT_W'(1);
               state_d   = S_IDLE;
            end else if (op_q == OP_HALT) begin
               retired_d = retired_q + CNT_W'(1);
               halted_d  = 1'b1;
               state_d   = S_HALT;
            end else begin
               asel_d  = srca_q;
               bsel_d  = srcb_q;
               go_d    = 1'b1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            tmr_clr = 1'b0;
            tmr_en  = 1'b1;
            // Done takes priority over the timer reaching its limit.
            if (ALU_DONE) begin
               dsel_d  = dst_q;
               state_d = S_WRITE;
            end else if (tmr_term) begin
               timeout_d = 1'b1;
               asel_d    = '0;
               bsel_d    = '0;
               state_d   = S_IDLE;
            end
         end
         S_WRITE: begin
            retired_d = retired_q + CNT_W'(1);
            asel_d    = '0;
            bsel_d    = '0;
            state_d   = S_IDLE;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            asel_d  = '0;
            bsel_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; async reset drops any in-flight write.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         dst_q     <= '0;
         srca_q    <= '0;
         srcb_q    <= '0;
         asel_q    <= '0;
         bsel_q    <= '0;
         dsel_q    <= '0;
         go_q      <= 1'b0;
         halted_q  <= 1'b0;
         timeout_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         dst_q     <= dst_d;
         srca_q    <= srca_d;
         srcb_q    <= srcb_d;
         asel_q    <= asel_d;
         bsel_q    <= bsel_d;
         dsel_q    <= dsel_d;
         go_q      <= go_d;
         halted_q  <= halted_d;
         timeout_q <= timeout_d;
         retired_q <= retired_d;
      end
   end

   assign IREADY  = (state_q == S_IDLE);
   assign ASEL    = asel_q;
   assign BSEL    = bsel_q;
   assign DSEL    = dsel_q;
   assign ALUOP   = op_q;
   assign ALU_GO  = go_q;
   assign HALTED  = halted_q;
   assign TIMEOUT = timeout_q;
   assign RETIRED = retired_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed self-checking bench for regfile_seq.
module tb_regfile_seq;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] INSTR;
   logic        IVALID;
   logic        IREADY;
   logic [2:0]  ASEL, BSEL, DSEL;
   logic [3:0]  ALUOP;
   logic        ALU_GO;
   logic        ALU_DONE;
   logic        HALTED;
   logic        TIMEOUT;
   logic [15:0] RETIRED;

   int n_cmp = 0;
   int n_err = 0;

   regfile_seq #(
      .TIMEOUT_CYC (15),
      .CNT_W       (16)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .INSTR    (INSTR),
      .IVALID   (IVALID),
      .IREADY   (IREADY),
      .ASEL     (ASEL),
      .BSEL     (BSEL),
      .DSEL     (DSEL),
      .ALUOP    (ALUOP),
      .ALU_GO   (ALU_GO),
      .ALU_DONE (ALU_DONE),
      .HALTED   (HALTED),
      .TIMEOUT  (TIMEOUT),
      .RETIRED  (RETIRED)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST      = 1'b0;
      INSTR    = '0;
      IVALID   = 1'b0;
      ALU_DONE = 1'b0;
      #2;
      check("rst_ireadyx", {31'd0, IREADY}, 32'd1);
      check("rst_asel", {29'd0, ASEL}, 32'd0);
      check("rst_bsel", {29'd0, BSEL}, 32'd0);
      check("rst_dsel", {29'd0, DSEL}, 32'd0);
      check("rst_aluop", {28'd0, ALUOP}, 32'd0);
      check("rst_go", {31'd0, ALU_GO}, 32'd0);
      check("rst_halted", {31'd0, HALTED}, 32'd0);
      check("rst_timeout", {31'd0, TIMEOUT}, 32'd0);
      check("rst_retired", {16'd0, RETIRED}, 32'd0);
      #10;
      RST = 1'b1;
      tick();
      check("rst_iready", {31'd0, IREADY}, 32'd1);

      // T1: minimum-latency ALU op 0x1450
      INSTR = 16'h1450; IVALID = 1'b1;
      tick();                                  // cycle 1 DECODE
      IVALID = 1'b0;
      check("t1_dec_iready", {31'd0, IREADY}, 32'd0);
      check("t1_dec_go", {31'd0, ALU_GO}, 32'd0);
      check("t1_dec_dsel", {29'd0, DSEL}, 32'd0);
      tick();                                  // cycle 2 EXEC
      check("t1_go", {31'd0, ALU_GO}, 32'd1);
      check("t1_asel", {29'd0, ASEL}, 32'd1);
      check("t1_bsel", {29'd0, BSEL}, 32'd2);
      check("t1_aluop", {28'd0, ALUOP}, 32'd1);
      check("t1_exec_dsel", {29'd0, DSEL}, 32'd0);
      ALU_DONE = 1'b1;
      tick();                                  // cycle 3 WRITE
      ALU_DONE = 1'b0;
      check("t1_wr_dsel", {29'd0, DSEL}, 32'd2);
      check("t1_wr_go", {31'd0, ALU_GO}, 32'd0);
      check("t1_wr_asel", {29'd0, ASEL}, 32'd1);
      tick();                                  // cycle 4 IDLE
      check("t1_post_dsel", {29'd0, DSEL}, 32'd0);
      check("t1_retired", {16'd0, RETIRED}, 32'd1);
      check("t1_iready", {31'd0, IREADY}, 32'd1);

      // T2: ALU_DONE 5 cycles after ALU_GO (op3 dst3 srcA4 srcB5)
      INSTR = 16'h3728; IVALID = 1'b1;
      tick();
      IVALID = 1'b0;
      tick();
      check("t2_go", {31'd0, ALU_GO}, 32'd1);
      check("t2_asel", {29'd0, ASEL}, 32'd4);
      check("t2_bsel", {29'd0, BSEL}, 32'd5);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("t2_go_low", {31'd0, ALU_GO}, 32'd0);
         check("t2_dsel_low", {29'd0, DSEL}, 32'd0);
         check("t2_asel_hold", {29'd0, ASEL}, 32'd4);
         if (i == 5) ALU_DONE = 1'b1;
      end
      tick();                                  // 6 cycles after GO
      ALU_DONE = 1'b0;
      check("t2_wr_dsel", {29'd0, DSEL}, 32'd3);
      tick();
      check("t2_post_dsel", {29'd0, DSEL}, 32'd0);
      check("t2_retired", {16'd0, RETIRED}, 32'd2);

      // T3: ALU never answers -> timeout after 15 EXEC cycles
      INSTR = 16'h2200; IVALID = 1'b1;
      tick();
      IVALID = 1'b0;
      tick();                                  // EXEC cycle 1
      check("t3_go", {31'd0, ALU_GO}, 32'd1);
      for (int k = 2; k <= 15; k++) begin
         tick();
         check("t3_to_low", {31'd0, TIMEOUT}, 32'd0);
         check("t3_dsel", {29'd0, DSEL}, 32'd0);
         check("t3_busy", {31'd0, IREADY}, 32'd0);
      end
      tick();
      check("t3_timeout", {31'd0, TIMEOUT}, 32'd1);
      check("t3_iready", {31'd0, IREADY}, 32'd1);
      check("t3_dsel_end", {29'd0, DSEL}, 32'd0);
      check("t3_retired", {16'd0, RETIRED}, 32'd2);
      INSTR = 16'h0000; IVALID = 1'b1;
      tick();
      IVALID = 1'b0;
      tick();
      check("t3_nop_retired", {16'd0, RETIRED}, 32'd3);
      check("t3_sticky", {31'd0, TIMEOUT}, 32'd1);

      // T4: back-to-back NOPs, then HALT, then ignored instructions
      INSTR = 16'h0000; IVALID = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         tick();
         check("t4_nop_busy", {31'd0, IREADY}, 32'd0);
         tick();
         check("t4_nop_ret", {16'd0, RETIRED}, 32'(3 + n));
         check("t4_nop_rdy", {31'd0, IREADY}, 32'd1);
      end
      INSTR = 16'hF000;
      tick();
      INSTR = 16'h1450;
      tick();
      check("t4_halted", {31'd0, HALTED}, 32'd1);
      check("t4_halt_ret", {16'd0, RETIRED}, 32'd7);
      for (int n = 0; n < 5; n++) begin
         tick();
         check("t4_h_rdy", {31'd0, IREADY}, 32'd0);
         check("t4_h_go", {31'd0, ALU_GO}, 32'd0);
         check("t4_h_asel", {29'd0, ASEL}, 32'd0);
         check("t4_h_dsel", {29'd0, DSEL}, 32'd0);
         check("t4_h_ret", {16'd0, RETIRED}, 32'd7);
      end
      IVALID = 1'b0;
      RST = 1'b0;
      #1;
      check("t4_rst_halted", {31'd0, HALTED}, 32'd0);
      check("t4_rst_timeout", {31'd0, TIMEOUT}, 32'd0);
      check("t4_rst_ret", {16'd0, RETIRED}, 32'd0);
      #2;
      RST = 1'b1;
      tick();
      check("t4_rdy", {31'd0, IREADY}, 32'd1);

      // T5: reset asserted during WRITE with dst=5 (op4 dst5 srcA6 srcB7)
      INSTR = 16'h4BB8; IVALID = 1'b1;
      tick();
      IVALID = 1'b0;
      tick();
      ALU_DONE = 1'b1;
      tick();
      ALU_DONE = 1'b0;
      check("t5_wr_dsel", {29'd0, DSEL}, 32'd5);
      RST = 1'b0;
      #1;
      check("t5_rst_dsel", {29'd0, DSEL}, 32'd0);
      check("t5_rst_asel", {29'd0, ASEL}, 32'd0);
      check("t5_rst_bsel", {29'd0, BSEL}, 32'd0);
      check("t5_rst_aluop", {28'd0, ALUOP}, 32'd0);
      check("t5_rst_ret", {16'd0, RETIRED}, 32'd0);
      #2;
      RST = 1'b1;
      tick();
      check("t5_rdy", {31'd0, IREADY}, 32'd1);
      check("t5_ret", {16'd0, RETIRED}, 32'd0);
      check("t5_dsel", {29'd0, DSEL}, 32'd0);

      // T6: stray ALU_DONE in IDLE, then dst=0 op (op5 srcA3 srcB1)
      ALU_DONE = 1'b1;
      tick();
      ALU_DONE = 1'b0;
      check("t6_idle_rdy", {31'd0, IREADY}, 32'd1);
      check("t6_idle_dsel", {29'd0, DSEL}, 32'd0);
      check("t6_idle_ret", {16'd0, RETIRED}, 32'd0);
      INSTR = 16'h50C8; IVALID = 1'b1;
      tick();
      IVALID = 1'b0;
      check("t6_dec_dsel", {29'd0, DSEL}, 32'd0);
      tick();
      check("t6_asel", {29'd0, ASEL}, 32'd3);
      check("t6_bsel", {29'd0, BSEL}, 32'd1);
      check("t6_aluop", {28'd0, ALUOP}, 32'd5);
      ALU_DONE = 1'b1;
      tick();
      ALU_DONE = 1'b0;
      check("t6_wr_dsel", {29'd0, DSEL}, 32'd0);
      tick();
      check("t6_ret", {16'd0, RETIRED}, 32'd1);
      check("t6_rdy", {31'd0, IREADY}, 32'd1);

      // T7: ALU_DONE in EXEC cycle 15 wins over timeout (op6 dst7 srcA2 srcB3)
      INSTR = 16'h6E98; IVALID = 1'b1;
      tick();
      IVALID = 1'b0;
      tick();                                  // EXEC cycle 1
      for (int k = 2; k <= 15; k++) tick();
      check("t7_busy", {31'd0, IREADY}, 32'd0);
      ALU_DONE = 1'b1;
      tick();
      ALU_DONE = 1'b0;
      check("t7_wr_dsel", {29'd0, DSEL}, 32'd7);
      check("t7_no_to", {31'd0, TIMEOUT}, 32'd0);
      tick();
      check("t7_ret", {16'd0, RETIRED}, 32'd2);
      check("t7_to_end", {31'd0, TIMEOUT}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
